// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: per-channel high/low phase lengths with
// shadowed config applied at period start, run enable, global phase-align sync and edge strobes.

module clock_divider_ch #(
  parameter int CNT_W    = 16,
  parameter int DEF_HIGH = 50,
  parameter int DEF_LOW  = 50
) (
  input  logic             clock50,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_high_i,
  input  logic [CNT_W-1:0] wr_low_i,
  output logic             clk_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             pending_o
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DH  = CNT_W'(DEF_HIGH);
  localparam logic [CNT_W-1:0] DL  = CNT_W'(DEF_LOW);

  state_e           st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_hi_q, act_hi_d, act_lo_q, act_lo_d;
  logic [CNT_W-1:0] shd_hi_q, shd_hi_d, shd_lo_q, shd_lo_d;
  logic             pend_q, pend_d;
  logic             rise_q, rise_d, fall_q, fall_d;
  logic             start;
  logic [CNT_W-1:0] hi_eff;

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    act_hi_d = act_hi_q;
    act_lo_d = act_lo_q;
    shd_hi_d = shd_hi_q;
    shd_lo_d = shd_lo_q;
    pend_d   = pend_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    start    = 1'b0;
    // Period start takes the pre-edge shadow, so a same-cycle write waits one period.
    hi_eff   = pend_q ? shd_hi_q : act_hi_q;

    if (sync_i && en_i) begin
      start = 1'b1;
    end else begin
      case (st_q)
        IDLE: if (en_i) start = 1'b1;
        HIGH: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
          end else if (en_i) begin
            st_d   = LOW;
            cnt_d  = act_lo_q - ONE;
            fall_d = 1'b1;
          end else begin
            st_d   = IDLE;
            fall_d = 1'b1;
          end
        end
        LOW: begin
          if (cnt_q != '0) cnt_d = cnt_q - ONE;
          else if (en_i)   start = 1'b1;
          else             st_d  = IDLE;
        end
        default: begin
          st_d  = IDLE;
          cnt_d = '0;
        end
      endcase
    end

    if (start) begin
      st_d   = HIGH;
      cnt_d  = hi_eff - ONE;
      rise_d = 1'b1;
      if (pend_q) begin
        act_hi_d = shd_hi_q;
        act_lo_d = shd_lo_q;
        pend_d   = 1'b0;
      end
    end

    if (wr_i) begin
      shd_hi_d = (wr_high_i == '0) ? ONE : wr_high_i;
      shd_lo_d = (wr_low_i  == '0) ? ONE : wr_low_i;
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      st_q     <= IDLE;
      cnt_q    <= '0;
      act_hi_q <= DH;
      act_lo_q <= DL;
      shd_hi_q <= DH;
      shd_lo_q <= DL;
      pend_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      act_hi_q <= act_hi_d;
      act_lo_q <= act_lo_d;
      shd_hi_q <= shd_hi_d;
      shd_lo_q <= shd_lo_d;
      pend_q   <= pend_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign clk_o     = (st_q == HIGH);
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign pending_o = pend_q;
endmodule

module clock_divider_multi #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter int DEF_HIGH = 50,
  parameter int DEF_LOW  = 50,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock50,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [CNT_W-1:0]  cfg_low,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] rise_stb,
  output logic [NUM_CH-1:0] fall_stb,
  output logic [NUM_CH-1:0] pending
);
  logic cfg_ok;
  assign cfg_ok = cfg_we && (int'(cfg_ch) < NUM_CH);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clock_divider_ch #(
      .CNT_W   (CNT_W),
      .DEF_HIGH(DEF_HIGH),
      .DEF_LOW (DEF_LOW)
    ) u_ch (
      .clock50  (clock50),
      .reset_n  (reset_n),
      .en_i     (en[g]),
      .sync_i   (sync),
      .wr_i     (cfg_ok && (cfg_ch == CH_W'(g))),
      .wr_high_i(cfg_high),
      .wr_low_i (cfg_low),
      .clk_o    (clk_out[g]),
      .rise_o   (rise_stb[g]),
      .fall_o   (fall_stb[g]),
      .pending_o(pending[g])
    );
  end
endmodule

// File: tb/tb_clock_divider_multi.sv
// Scoreboarded bench: stimulus queues expected strobe events per channel (edge number, kind),
// a forked monitor pops and checks every strobe the DUT produces.
module tb_clock_divider_multi;
  localparam int NCH = 3;
  localparam int CW  = 16;
  localparam int CHW = 2;

  logic           clock50 = 1'b0;
  logic           reset_n = 1'b0;
  logic [NCH-1:0] en = '0;
  logic           sync = 1'b0;
  logic           cfg_we = 1'b0;
  logic [CHW-1:0] cfg_ch = '0;
  logic [CW-1:0]  cfg_high = '0, cfg_low = '0;
  logic [NCH-1:0] clk_out, rise_stb, fall_stb, pending;

  typedef struct { bit rise; int at; } ev_t;
  ev_t expq[NCH][$];
  int  checks = 0, failures = 0, cyc = 0, t0 = 0;

  clock_divider_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEF_HIGH(50), .DEF_LOW(50)) dut (
    .clock50(clock50), .reset_n(reset_n), .en(en), .sync(sync),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_high(cfg_high), .cfg_low(cfg_low),
    .clk_out(clk_out), .rise_stb(rise_stb), .fall_stb(fall_stb), .pending(pending)
  );

  always #5 clock50 = ~clock50;
  always @(posedge clock50) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic ex(input int ch, input bit r, input int at);
    ev_t e;
    e.rise = r;
    e.at   = t0 + at;
    expq[ch].push_back(e);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clock50);
      if (reset_n) begin
        for (int c = 0; c < NCH; c++) begin
          if (rise_stb[c] || fall_stb[c]) begin
            ev_t e;
            checks++;
            if (rise_stb[c] && fall_stb[c]) begin
              failures++;
              $display("FAIL ev_ch%0d: got both strobes at edge %0d expected one", c, cyc - t0);
            end else if (expq[c].size() == 0) begin
              failures++;
              $display("FAIL ev_ch%0d: got unexpected %s at edge %0d expected none", c,
                       rise_stb[c] ? "rise" : "fall", cyc - t0);
            end else begin
              e = expq[c].pop_front();
              if (e.rise != rise_stb[c] || e.at != cyc || clk_out[c] != rise_stb[c]) begin
                failures++;
                $display("FAIL ev_ch%0d: got %s@%0d clk=%0b expected %s@%0d", c,
                         rise_stb[c] ? "rise" : "fall", cyc - t0, clk_out[c],
                         e.rise ? "rise" : "fall", e.at - t0);
              end
            end
          end
        end
      end
    end
  endtask

  task automatic wait_to(input int k);
    while (cyc < t0 + k) @(negedge clock50);
  endtask

  task automatic drain();
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("missing_ev_ch%0d", c), expq[c].size(), 0);
      expq[c].delete();
    end
  endtask

  task automatic do_reset(input bit check_outs);
    @(negedge clock50);
    reset_n = 1'b0; en = '0; sync = 1'b0; cfg_we = 1'b0;
    repeat (3) @(negedge clock50);
    if (check_outs) begin
      chk("rst_clk_out", int'(clk_out), 0);
      chk("rst_rise", int'(rise_stb), 0);
      chk("rst_fall", int'(fall_stb), 0);
      chk("rst_pending", int'(pending), 0);
    end
    reset_n = 1'b1;
    t0 = cyc;
  endtask

  task automatic wr(input int ch, input int hi, input int lo);
    cfg_we = 1'b1; cfg_ch = CHW'(ch); cfg_high = CW'(hi); cfg_low = CW'(lo);
  endtask

  initial begin
    fork monitor(); join_none

    // Default 50/50 on ch0, then en drop mid-HIGH and re-raise.
    do_reset(1'b1);
    en = 3'b001;
    ex(0,1,1); ex(0,0,51); ex(0,1,101); ex(0,0,151); ex(0,1,201); ex(0,0,251);
    wait_to(25);  chk("a_clk_high", int'(clk_out), 1);
    wait_to(75);  chk("a_clk_low", int'(clk_out), 0);
    wait_to(230); en[0] = 1'b0;
    wait_to(300); chk("a_idle", int'(clk_out), 0);
    wait_to(400); en[0] = 1'b1;
    ex(0,1,401); ex(0,0,451);
    wait_to(401); chk("a_reraise_clk", int'(clk_out), 1);
    en[0] = 1'b0;
    wait_to(520); drain();

    // Shadow config, zero->1 clamp, out-of-range write, same-cycle write at period start.
    do_reset(1'b0);
    en = 3'b011;
    ex(0,1,1); ex(0,0,51); ex(0,1,101); ex(0,0,151);
    ex(1,1,1); ex(1,0,51); ex(1,1,101); ex(1,0,104); ex(1,1,109); ex(1,0,113); ex(1,1,117); ex(1,0,121);
    for (int k = 31; k <= 40; k++) ex(2, (k % 2) == 1, k);
    wait_to(10);  wr(1, 3, 5);
    wait_to(11);  cfg_we = 1'b0; chk("b_pend_ch1", int'(pending), 3'b010);
    wait_to(20);  wr(2, 0, 1);
    wait_to(21);  wr(3, 9, 9);
    wait_to(22);  cfg_we = 1'b0; chk("b_pend_oor", int'(pending), 3'b110);
    wait_to(30);  en[2] = 1'b1;
    wait_to(39);  en[2] = 1'b0;
    wait_to(60);  chk("b_clk_mid", int'(clk_out), 0);
    wait_to(100); wr(1, 4, 4);
    wait_to(101); cfg_we = 1'b0; chk("b_pend_collide", int'(pending), 3'b010);
    wait_to(102); chk("b_clk_new", int'(clk_out), 3'b011);
    wait_to(109); chk("b_pend_applied", int'(pending), 0);
    wait_to(118); en = 3'b000;
    wait_to(200); drain();

    // Sync phase-align (incl. ch0 at count 0), then async reset mid-period.
    do_reset(1'b0);
    en = 3'b001;
    ex(0,1,1); ex(0,1,51); ex(0,0,101); ex(0,1,151);
    ex(1,1,21); ex(1,1,51); ex(1,0,101); ex(1,1,151);
    wait_to(20);  en[1] = 1'b1;
    wait_to(50);  sync = 1'b1;
    wait_to(51);  sync = 1'b0; chk("c_sync_clk", int'(clk_out), 3'b011);
    chk("c_sync_nofall", int'(fall_stb), 0);
    wait_to(120); chk("c_aligned_low", int'(clk_out), 0);
    wait_to(155); wr(0, 2, 2);
    wait_to(156); cfg_we = 1'b0; chk("c_pend", int'(pending), 3'b001);
    wait_to(160);
    #2 reset_n = 1'b0;
    #1 chk("c_rst_clk", int'(clk_out), 0);
    chk("c_rst_pend", int'(pending), 0);
    drain();
    do_reset(1'b0);
    en = 3'b001;
    ex(0,1,1); ex(0,0,51); ex(0,1,101); ex(0,0,151);
    wait_to(1);   chk("c_post_pend", int'(pending), 0);
    wait_to(102); en = 3'b000;
    wait_to(220); drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
